// File: rtl/iter_divider_if.sv
// Request/response handshake bundle for the iterative divider.
// The issue side uses master; the divider uses slave.
interface iter_divider_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 6
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_op;
  logic [WIDTH-1:0]     req_dividend;
  logic [WIDTH-1:0]     req_divisor;
  logic [TAG_WIDTH-1:0] req_tag;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [WIDTH-1:0]     resp_result;
  logic [TAG_WIDTH-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_dividend, req_divisor, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_dividend, req_divisor, req_tag, resp_ready,
    output req_ready, resp_valid, resp_result, resp_tag
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved at accept and skip the iteration.
module iter_divider #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 6
) (
  input  logic           clk,
  input  logic           rst_aL,
  input  logic           flush,
  iter_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     divisor_q, divisor_d;
  logic [1:0]           op_q, op_d;
  logic                 quo_neg_q, quo_neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;

  logic                 signed_op;
  logic                 dvd_neg, dvs_neg;
  logic [WIDTH-1:0]     abs_dvd, abs_dvs;
  logic                 div_zero, overflow;
  logic [WIDTH:0]       rem_sh, trial;
  logic [WIDTH-1:0]     rem_next, quo_next;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    op_d      = op_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    tag_d     = tag_q;

    signed_op = ~bus.req_op[0];
    dvd_neg   = signed_op & bus.req_dividend[WIDTH-1];
    dvs_neg   = signed_op & bus.req_divisor[WIDTH-1];
    abs_dvd   = dvd_neg ? -bus.req_dividend : bus.req_dividend;
    abs_dvs   = dvs_neg ? -bus.req_divisor : bus.req_divisor;
    div_zero  = (bus.req_divisor == '0);
    overflow  = signed_op && (bus.req_dividend == MIN_VAL) && (bus.req_divisor == '1);

    // The remainder stays below the divisor, so bit WIDTH of trial is a true sign bit.
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    trial    = rem_sh - {1'b0, divisor_q};
    rem_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    quo_fix  = quo_neg_q ? -quo_next : quo_next;
    rem_fix  = rem_neg_q ? -rem_next : rem_next;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d  = bus.req_op;
          tag_d = bus.req_tag;
          if (div_zero) begin
            result_d = bus.req_op[1] ? bus.req_dividend : '1;
            state_d  = DONE;
          end else if (overflow) begin
            result_d = bus.req_op[1] ? '0 : MIN_VAL;
            state_d  = DONE;
          end else begin
            rem_d     = '0;
            quo_d     = abs_dvd;
            divisor_d = abs_dvs;
            quo_neg_d = dvd_neg ^ dvs_neg;
            rem_neg_d = dvd_neg;
            cnt_d     = CNT_W'(WIDTH-1);
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_next;
        quo_d = quo_next;
        if (cnt_q == '0) begin
          result_d = op_q[1] ? rem_fix : quo_fix;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flushed request never latches: restore every field the accept path touched.
    if (flush) begin
      state_d   = IDLE;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      divisor_d = divisor_q;
      op_d      = op_q;
      quo_neg_d = quo_neg_q;
      rem_neg_d = rem_neg_q;
      result_d  = result_q;
      tag_d     = tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      op_q      <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      op_q      <= op_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      tag_q     <= tag_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = (state_q == DONE);
  assign bus.resp_result = result_q;
  assign bus.resp_tag    = tag_q;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: stimulus pushes expected responses,
// a negedge monitor pops and compares them as the divider returns results.
module tb_iter_divider;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  typedef struct {
    logic [31:0] result;
    logic [5:0]  tag;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_aL = 1'b0;
  logic flush = 1'b0;

  iter_divider_if #(.WIDTH(32), .TAG_WIDTH(6)) bus ();

  iter_divider #(.WIDTH(32), .TAG_WIDTH(6)) dut (
    .clk    (clk),
    .rst_aL (rst_aL),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  exp_t        expQ[$];
  int          checks = 0;
  int          passes = 0;
  int          cycleCnt = 0;
  int          acceptCycle = 0;
  int          risingLat = 0;
  logic        prevValid = 1'b0;
  logic [31:0] prevResult = '0;
  logic [5:0]  prevTag = '0;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, actual, expected, $time);
    else
      passes++;
  endtask

  function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Monitor: measures latency on the rising edge of resp_valid, checks hold
  // behaviour under backpressure and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (bus.resp_valid) begin
      if (!prevValid) begin
        risingLat = cycleCnt - acceptCycle + 1;
      end else begin
        checkOutput("hold_result", bus.resp_result, prevResult);
        checkOutput("hold_tag", 32'(bus.resp_tag), 32'(prevTag));
      end
      checkOutput("req_ready_busy", 32'(bus.req_ready), 32'd0);
      if (bus.resp_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_resp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("result", bus.resp_result, e.result);
          checkOutput("tag", 32'(bus.resp_tag), 32'(e.tag));
          checkOutput("latency", 32'(risingLat), 32'(e.lat));
        end
      end
      prevResult = bus.resp_result;
      prevTag    = bus.resp_tag;
    end
    prevValid = bus.resp_valid && !bus.resp_ready;
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [5:0] tag, input logic [31:0] expRes, input int expLat,
                               input bit doPush);
    int waitCnt;
    waitCnt = 0;
    @(posedge clk); #1;
    while (!bus.req_ready && waitCnt < 100) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!bus.req_ready) begin
      checkOutput("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    bus.req_tag      = tag;
    acceptCycle      = cycleCnt + 1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (doPush) expQ.push_back('{expRes, tag, expLat});
  endtask

  task automatic waitValid(output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 60) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        ok = 1'b1;
        return;
      end
      n++;
    end
    checkOutput("resp_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    bus.req_valid    = 1'b0;
    bus.req_op       = 2'b00;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.req_tag      = '0;
    bus.resp_ready   = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("rst_result", bus.resp_result, 32'd0);
    checkOutput("rst_tag", 32'(bus.resp_tag), 32'd0);
    rst_aL = 1'b1;

    // Basic unsigned and signed fix-up cases
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 6'd5, 32'd14, 33, 1'b1);
    applyStimulus(OP_REMU, 32'd100, 32'd7, 6'd6, 32'd2, 33, 1'b1);
    applyStimulus(OP_DIV,  32'hFFFF_FFF9, 32'd2, 6'd7, 32'hFFFF_FFFD, 33, 1'b1);
    applyStimulus(OP_REM,  32'hFFFF_FFF9, 32'd2, 6'd8, 32'hFFFF_FFFF, 33, 1'b1);
    applyStimulus(OP_REM,  32'd7, 32'hFFFF_FFFE, 6'd9, 32'd1, 33, 1'b1);
    applyStimulus(OP_DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFE, 6'd10, 32'd4, 33, 1'b1);

    // Special cases resolve one cycle after accept
    applyStimulus(OP_DIV,  32'h1234, 32'd0, 6'd11, 32'hFFFF_FFFF, 1, 1'b1);
    applyStimulus(OP_REMU, 32'h1234, 32'd0, 6'd12, 32'h1234, 1, 1'b1);
    applyStimulus(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 6'd13, 32'h8000_0000, 1, 1'b1);
    applyStimulus(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 6'd14, 32'd0, 1, 1'b1);
    drain();

    // Backpressure: hold DONE for 10 cycles, then a single handshake
    bus.resp_ready = 1'b0;
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 6'd20, 32'd14, 33, 1'b1);
    waitValid(ok);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_req_ready_after", 32'(bus.req_ready), 32'd1);
    checkOutput("bp_resp_valid_after", 32'(bus.resp_valid), 32'd0);
    checkOutput("bp_queue_empty", 32'(expQ.size()), 32'd0);

    // Flush during CALC kills the operation
    applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 6'd21, 32'd0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_calc_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("flush_calc_ready", 32'(bus.req_ready), 32'd1);
    repeat (40) @(posedge clk);
    applyStimulus(OP_DIVU, 32'd9, 32'd3, 6'd22, 32'd3, 33, 1'b1);
    drain();

    // Flush while in DONE drops the response
    bus.resp_ready = 1'b0;
    applyStimulus(OP_DIVU, 32'd9, 32'd3, 6'd23, 32'd0, 0, 1'b0);
    waitValid(ok);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.resp_ready = 1'b1;
    checkOutput("flush_done_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("flush_done_ready", 32'(bus.req_ready), 32'd1);
    repeat (5) @(posedge clk);

    // A request presented together with flush is ignored
    #1;
    flush            = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_op       = OP_DIVU;
    bus.req_dividend = 32'd9;
    bus.req_divisor  = 32'd0;
    bus.req_tag      = 6'd24;
    @(posedge clk); #1;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    checkOutput("flush_accept_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("flush_accept_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("flush_accept_tag", 32'(bus.resp_tag), 32'd23);
    repeat (5) @(posedge clk);

    // Asynchronous reset mid-CALC
    applyStimulus(OP_DIVU, 32'd1000, 32'd7, 6'd25, 32'd0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_aL = 1'b0;
    #1;
    checkOutput("arst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("arst_result", bus.resp_result, 32'd0);
    checkOutput("arst_tag", 32'(bus.resp_tag), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_aL = 1'b1;
    @(posedge clk); #1;
    checkOutput("arst_release_ready", 32'(bus.req_ready), 32'd1);
    repeat (40) @(posedge clk);

    // Mixed random operations against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b, exp;
      int          lat;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = $urandom();
        1: a = 32'($urandom_range(0, 1000));
        2: a = -32'($urandom_range(1, 1000));
        default: a = 32'h8000_0000;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2, 3: b = 32'($urandom_range(1, 50));
        4: b = -32'($urandom_range(1, 50));
        default: b = $urandom();
      endcase
      exp = refResult(op, a, b);
      lat = (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      applyStimulus(op, a, b, 6'(i), exp, lat, 1'b1);
    end
    drain();

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
